// File: rtl/ht1080z_pkg.sv
// Shared types and default timing for the HT1080Z cassette playback path.
package ht1080z_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WAIT = 2'd2
  } tape_state_t;

  // 2 ms bit cell and 125 us pulse at 56 MHz.
  localparam int TAPE_BIT_CLKS   = 112000;
  localparam int TAPE_PULSE_CLKS = 7000;

endpackage

// File: rtl/cas_fifo.sv
// Synchronous FIFO holding {last, data} CAS entries between download and playback.
module cas_fifo #(
  parameter int AW = 4,
  parameter int W  = 9
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cas_tape_player.sv
// Serialises buffered CAS bytes into the TRS-80 Level II 500-baud pulse waveform.
module cas_tape_player
  import ht1080z_pkg::*;
#(
  parameter int BIT_CLKS   = TAPE_BIT_CLKS,
  parameter int PULSE_CLKS = TAPE_PULSE_CLKS,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       motor_on,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] CELL_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] PULSE_END  = CW'(PULSE_CLKS);
  localparam logic [CW-1:0] DATA_START = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] DATA_END   = CW'(BIT_CLKS / 2 + PULSE_CLKS);

  // Handshake: a byte moves into the FIFO on any rising edge where
  // in_valid & in_ready; in_ready depends only on FIFO occupancy.

  tape_state_t   state, state_d;
  logic [CW-1:0] cell_cnt, cell_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          last_reg, last_d;
  logic          tape_d, busy_d, done_d;
  logic          pop;
  logic [8:0]    fifo_rd;
  logic          fifo_full, fifo_empty;

  assign in_ready = ~fifo_full;

  cas_fifo #(
    .AW (FIFO_AW),
    .W  (9)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (in_valid),
    .wr_data ({in_last, in_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cell_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      last_reg <= 1'b0;
      tape_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cell_cnt <= cell_d;
      bit_idx  <= bit_d;
      shreg    <= shreg_d;
      last_reg <= last_d;
      tape_out <= tape_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cell_d  = cell_cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    last_d  = last_reg;
    pop     = 1'b0;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty && motor_on) begin
          pop     = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (motor_on) begin
          if (cell_cnt == CELL_LAST) begin
            cell_d  = '0;
            shreg_d = {shreg[6:0], 1'b0};
            bit_d   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (last_reg) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else if (!fifo_empty) begin
                pop = 1'b1;
              end else begin
                state_d = WAIT;
              end
            end
          end else begin
            cell_d = cell_cnt + CW'(1);
          end
        end
      end
      WAIT: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any pop starts a fresh byte at cell offset 0.
    if (pop) begin
      shreg_d = fifo_rd[7:0];
      last_d  = fifo_rd[8];
      cell_d  = '0;
      bit_d   = '0;
    end

    // Outputs are computed from next-state values so they register in step with the counter.
    tape_d = (state_d == PLAY) && motor_on &&
             ((cell_d < PULSE_END) ||
              (shreg_d[7] && (cell_d >= DATA_START) && (cell_d < DATA_END)));
    busy_d = (state_d != IDLE);
  end

endmodule
